// File: rtl/flush_sequencer_pkg.sv
// flush_sequencer_pkg: shared state encoding and fence-operation bundle for the flush sequencer.
//   flush_state_e : IDLE, FLUSH_D, FLUSH_I, DONE (fixed 2-bit encoding)
//   fence_op_t    : one bit per committed fence flavour
package flush_sequencer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FLUSH_D = 2'd1;
    localparam logic [1:0] ST_FLUSH_I = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        FLUSH_D = ST_FLUSH_D,
        FLUSH_I = ST_FLUSH_I,
        DONE    = ST_DONE
    } flush_state_e;

    typedef struct packed {
        logic fence;
        logic fence_i;
        logic sfence;
        logic hvvma;
        logic hgvma;
    } fence_op_t;

endpackage

// File: rtl/flush_sequencer_ack.sv
// flush_ack_tracker: per-channel pending mask, loaded all-ones, each bit cleared by its ack.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : set every channel pending
//   abort     : drop every pending channel
//   ack       : per-channel acknowledge, ignored where nothing is pending
//   pending   : registered pending mask
//   all_done  : no channel is left pending once this cycle's acks are applied
module flush_ack_tracker #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         abort,
    input  logic [N-1:0] ack,
    output logic [N-1:0] pending,
    output logic         all_done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else if (load) pending <= '1;
        else if (abort) pending <= '0;
        else pending <= pending & ~ack;
    end

    assign all_done = ~|(pending & ~ack);

endmodule

// File: rtl/flush_sequencer.sv
// flush_sequencer: sequences fence/fence.i/sfence.vma/hfence flushes across D-cache banks, I-cache and TLBs.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   v_i, *_req_i, *fence*_i: virtualization mode and committed fence requests
//   halt_csr_i             : WFI halt from CSR
//   set_pc_commit_o, flush_pipeline_o, flush_tlb*_o : accept-cycle actions
//   flush_dcache_o/ack_i   : per-bank D-cache flush handshake
//   flush_icache_o/ack_i   : I-cache flush (pulse or handshake)
//   halt_o, busy_o, done_o, timeout_o : sequencing status
module flush_sequencer
    import flush_sequencer_pkg::*;
#(
    parameter int unsigned NrDcacheChan  = 2,
    parameter bit          DcacheWb      = 1'b1,
    parameter bit          IcacheAck     = 1'b0,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned TimeoutW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    v_i,
    input  logic                    fence_req_i,
    input  logic                    fence_i_req_i,
    input  logic                    sfence_vma_i,
    input  logic                    hfence_vvma_i,
    input  logic                    hfence_gvma_i,
    input  logic                    halt_csr_i,
    output logic                    set_pc_commit_o,
    output logic                    flush_pipeline_o,
    output logic                    flush_tlb_o,
    output logic                    flush_tlb_vvma_o,
    output logic                    flush_tlb_gvma_o,
    output logic [NrDcacheChan-1:0] flush_dcache_o,
    input  logic [NrDcacheChan-1:0] flush_dcache_ack_i,
    output logic                    flush_icache_o,
    input  logic                    flush_icache_ack_i,
    output logic                    halt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o
);

    flush_state_e            state, state_next;
    fence_op_t               op;
    logic                    accept, go_d, need_i, waiting, timeout, d_done, icache_pulse;
    logic [NrDcacheChan-1:0] pending_d;
    logic [TimeoutW-1:0]     cnt;

    assign op = '{fence: fence_req_i, fence_i: fence_i_req_i, sfence: sfence_vma_i,
                  hvvma: hfence_vvma_i, hgvma: hfence_gvma_i};

    // Gated by reset so every output is low while reset is held.
    assign accept  = !rst_i && state == IDLE && op != '0;
    assign go_d    = DcacheWb && (op.fence || op.fence_i);
    assign waiting = state == FLUSH_D || state == FLUSH_I;
    assign timeout = TimeoutCycles != 0 && waiting && cnt == TimeoutW'(TimeoutCycles);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = go_d ? FLUSH_D : (op.fence_i && IcacheAck) ? FLUSH_I : DONE;
            FLUSH_D: if (timeout || d_done) state_next = (!timeout && need_i && IcacheAck) ? FLUSH_I : DONE;
            FLUSH_I: if (timeout || flush_icache_ack_i) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            need_i <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            need_i <= accept ? op.fence_i : timeout ? 1'b0 : need_i;
            cnt    <= state_next != state ? '0 : waiting ? cnt + TimeoutW'(1) : cnt;
        end
    end

    flush_ack_tracker #(.N(NrDcacheChan)) u_dack (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (accept && go_d),
        .abort    (timeout),
        .ack      (flush_dcache_ack_i),
        .pending  (pending_d),
        .all_done (d_done)
    );

    // Without a handshake the I-cache flush is a pulse issued only once the D-cache side has finished.
    assign icache_pulse = !IcacheAck && ((accept && !go_d && op.fence_i) ||
                                         (state == FLUSH_D && d_done && !timeout && need_i));

    assign set_pc_commit_o  = accept;
    assign flush_pipeline_o = accept;
    assign flush_tlb_o      = accept && op.sfence && !v_i;
    assign flush_tlb_vvma_o = accept && ((op.sfence && v_i) || op.hvvma);
    assign flush_tlb_gvma_o = accept && op.hgvma;
    assign flush_dcache_o   = timeout ? '0 : pending_d;
    assign flush_icache_o   = (state == FLUSH_I && !timeout) || icache_pulse;
    assign busy_o           = state != IDLE;
    assign halt_o           = !rst_i && (halt_csr_i || busy_o);
    assign done_o           = state == DONE;
    assign timeout_o        = timeout;

    a_busy_ignores_requests: assert property (@(posedge clk_i) disable iff (rst_i) busy_o |-> !accept);

endmodule

// File: tb/tb_flush_sequencer.sv
// tb_flush_sequencer: table vectors, hand-written corner sequences and a randomized timeline-model check.
module tb_flush_sequencer;

    logic       clk = 1'b0, rst = 1'b1, v, fence, fence_i, sfence, hvvma, hgvma, halt_csr, iack;
    logic [1:0] dack;
    logic       set_pc, fpipe, tlb, tvv, tgv, fic, halt, busy, done, to;
    logic [1:0] fdc;
    logic [12:0] obs;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    flush_sequencer #(.NrDcacheChan(2), .DcacheWb(1'b1), .IcacheAck(1'b1), .TimeoutCycles(16)) dut (
        .clk_i(clk), .rst_i(rst), .v_i(v), .fence_req_i(fence), .fence_i_req_i(fence_i),
        .sfence_vma_i(sfence), .hfence_vvma_i(hvvma), .hfence_gvma_i(hgvma), .halt_csr_i(halt_csr),
        .set_pc_commit_o(set_pc), .flush_pipeline_o(fpipe), .flush_tlb_o(tlb), .flush_tlb_vvma_o(tvv),
        .flush_tlb_gvma_o(tgv), .flush_dcache_o(fdc), .flush_dcache_ack_i(dack), .flush_icache_o(fic),
        .flush_icache_ack_i(iack), .halt_o(halt), .busy_o(busy), .done_o(done), .timeout_o(to)
    );

    assign obs = {set_pc, fpipe, tlb, tvv, tgv, fdc, fic, halt, busy, done, to};

    typedef struct packed {
        logic       v;
        logic [4:0] r;
        logic [4:0] acc;
        logic [1:0] d1;
        logic       dn1;
    } vec_t;
    vec_t vec [9];

    function automatic logic [12:0] ev(input logic [4:0] acc, input logic [1:0] d, input logic ic, h, b, dn, t);
        return {acc, d, ic, h, b, dn, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        {fence, fence_i, sfence, hvvma, hgvma} = 5'd0;
        v = 1'b0; halt_csr = 1'b0; dack = 2'b00; iack = 1'b0;
    endtask

    task automatic req(input logic [4:0] r, input logic vv);
        {fence, fence_i, sfence, hvvma, hgvma} = r;
        v = vv;
    endtask

    task automatic chk(input string name, input logic [12:0] exp);
        #1;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (sp fp tlb vv gv d1 d0 ic halt busy done to)", name, obs, exp);
        end
    endtask

    task automatic drain();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            dack = 2'b11; iack = 1'b1;
            #1;
            seen = done;
            step();
        end
        idle_in();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL drain got=no_done exp=done_within_40");
        end
    endtask

    task automatic gap(input int n);
        logic hc;
        for (int i = 0; i < n; i++) begin
            hc = 1'($urandom_range(0, 2) == 0);
            halt_csr = hc;
            chk("gap", ev(5'd0, 2'b00, 1'b0, hc, 1'b0, 1'b0, 1'b0));
            step();
        end
        halt_csr = 1'b0;
    endtask

    // Expected behaviour is derived from an up-front ack schedule: bank k acks a[k] cycles into the
    // D phase, the I-cache acks b cycles into the I phase, and any wait reaching 16 cycles times out.
    task automatic rand_txn();
        logic [4:0] r, acc;
        logic [1:0] d;
        logic       hc, vv, ic;
        int         a [2];
        int         b, m, istart, done_t, to_t;
        bit         dph, ip;
        r = 5'($urandom_range(1, 31));
        for (int k = 0; k < 2; k++)
            a[k] = ($urandom_range(0, 6) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 5));
        b = ($urandom_range(0, 6) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 5));
        dph = r[4] | r[3]; ip = 1'b0; istart = 0; to_t = -1;
        m = (a[0] > a[1]) ? a[0] : a[1];
        if (!dph) done_t = 1;
        else if (m >= 16) begin to_t = 17; done_t = 18; end
        else if (r[3]) begin
            ip = 1'b1; istart = m + 2;
            if (b >= 16) begin to_t = istart + 16; done_t = istart + 17; end
            else done_t = istart + b + 1;
        end else done_t = m + 2;
        for (int t = 0; t <= done_t; t++) begin
            vv = 1'($urandom); hc = 1'($urandom_range(0, 3) == 0);
            v = vv; halt_csr = hc;
            {fence, fence_i, sfence, hvvma, hgvma} = (t == 0) ? r : ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            for (int k = 0; k < 2; k++)
                dack[k] = dph ? (t == 1 + a[k]) || (t > 1 + a[k] && $urandom_range(0, 1) == 1) : 1'($urandom);
            iack = ip && t == istart + b;
            acc = (t == 0) ? {2'b11, r[2] & ~vv, (r[2] & vv) | r[1], r[0]} : 5'd0;
            for (int k = 0; k < 2; k++)
                d[k] = dph && t >= 1 && t <= ((1 + a[k] < 16) ? 1 + a[k] : 16);
            ic = ip && t >= istart && t <= istart + ((b < 15) ? b : 15);
            chk("rand", ev(acc, d, ic, hc | (t >= 1), t >= 1, t == done_t, t == to_t));
            step();
        end
        idle_in();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        vec = '{
            '{1'b1, 5'b00100, 5'b11010, 2'b00, 1'b1},
            '{1'b0, 5'b00100, 5'b11100, 2'b00, 1'b1},
            '{1'b0, 5'b00010, 5'b11010, 2'b00, 1'b1},
            '{1'b1, 5'b00001, 5'b11001, 2'b00, 1'b1},
            '{1'b0, 5'b10001, 5'b11001, 2'b11, 1'b0},
            '{1'b1, 5'b01000, 5'b11000, 2'b11, 1'b0},
            '{1'b1, 5'b11111, 5'b11011, 2'b11, 1'b0},
            '{1'b0, 5'b00110, 5'b11110, 2'b00, 1'b1},
            '{1'b1, 5'b00011, 5'b11011, 2'b00, 1'b1}
        };
        idle_in();
        req(5'b10000, 1'b0);
        #2;
        chk("reset", 13'd0);
        idle_in();
        step(); step();
        rst = 1'b0;
        step();
        chk("idle", 13'd0);

        for (int i = 0; i < 9; i++) begin
            step();
            req(vec[i].r, vec[i].v);
            chk("tbl_acc", ev(vec[i].acc, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            step();
            idle_in();
            chk("tbl_next", ev(5'd0, vec[i].d1, 1'b0, 1'b1, 1'b1, vec[i].dn1, 1'b0));
            drain();
        end

        req(5'b10000, 1'b0);
        chk("fence_acc", ev(5'b11000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(); idle_in();
        chk("fence_c1", ev(5'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(); step();
        dack = 2'b01;
        chk("fence_c3", ev(5'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(); dack = 2'b00;
        chk("fence_c4", ev(5'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(); dack = 2'b10;
        chk("fence_c5", ev(5'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(); dack = 2'b00;
        chk("fence_done", ev(5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step();
        chk("fence_idle", 13'd0);

        step();
        req(5'b01000, 1'b0);
        chk("fi_acc", ev(5'b11000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(); idle_in(); dack = 2'b11;
        chk("fi_dphase", ev(5'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(); dack = 2'b00;
        chk("fi_iphase", ev(5'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        step();
        chk("fi_hold", ev(5'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        step(); iack = 1'b1;
        chk("fi_ack", ev(5'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        step(); iack = 1'b0;
        chk("fi_done", ev(5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step();

        req(5'b10000, 1'b0);
        chk("to_acc", ev(5'b11000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(); idle_in(); dack = 2'b01;
        chk("to_c1", ev(5'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 2; i <= 16; i++) begin
            step(); dack = 2'b00;
            chk("to_wait", ev(5'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        end
        step();
        chk("to_pulse", ev(5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
        step();
        chk("to_done", ev(5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step();
        chk("to_idle", 13'd0);

        step();
        req(5'b10000, 1'b0);
        chk("busy_acc", ev(5'b11000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        req(5'b01101, 1'b0);
        chk("busy_ignore", ev(5'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        idle_in(); dack = 2'b11;
        step(); dack = 2'b00;
        chk("busy_done", ev(5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step();

        req(5'b10000, 1'b0);
        chk("rst_acc0", ev(5'b11000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(); idle_in();
        chk("rst_pre", ev(5'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step();
        #1 rst = 1'b1;
        chk("rst_async", 13'd0);
        step(); step();
        rst = 1'b0;
        step();
        req(5'b10000, 1'b0);
        chk("rst_acc", ev(5'b11000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(); idle_in();
        chk("rst_d", ev(5'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        drain();

        for (int n = 0; n < 150; n++) begin
            gap($urandom_range(0, 2));
            rand_txn();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flush_sequencer.md
Name: flush_sequencer

Overview:
- Parametrised successor of the core flush controller. Sequences multi-cycle fence operations (fence, fence.i, sfence.vma, hfence.vvma, hfence.gvma) against N independently acknowledged D-cache flush channels and an optionally acknowledged I-cache flush.
- Sits between commit/CSR and the cache/TLB subsystems. Halts commit while a sequence is in flight and adds timeout recovery.

Parameters:
- NrDcacheChan, 2, number of D-cache flush req/ack channels (banks); range 1..8.
- DcacheWb, 1, 1 = D-cache is write-back and must be flushed on fence/fence.i; 0 = no D-cache flush is issued.
- IcacheAck, 0, 1 = I-cache flush uses a req/ack handshake; 0 = single-cycle pulse.
- TimeoutCycles, 1024, maximum cycles to wait for acks; 0 disables the timeout.
- TimeoutW, $clog2(TimeoutCycles+1), derived counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- v_i  in  1  virtualization mode
- fence_req_i  in  1  fence committed
- fence_i_req_i  in  1  fence.i committed
- sfence_vma_i  in  1  sfence.vma committed
- hfence_vvma_i  in  1  hfence.vvma committed
- hfence_gvma_i  in  1  hfence.gvma committed
- halt_csr_i  in  1  WFI halt from CSR
- set_pc_commit_o  out  1  redirect PC to commit PC
- flush_pipeline_o  out  1  flush IF/ID/EX and unissued instructions
- flush_tlb_o  out  1  flush TLBs (non-virtualized)
- flush_tlb_vvma_o  out  1  flush VS-stage TLB entries
- flush_tlb_gvma_o  out  1  flush G-stage TLB entries
- flush_dcache_o  out  NrDcacheChan  per-channel D-cache flush request
- flush_dcache_ack_i  in  NrDcacheChan  per-channel acknowledge
- flush_icache_o  out  1  I-cache flush
- flush_icache_ack_i  in  1  I-cache acknowledge (used only when IcacheAck=1)
- halt_o  out  1  halt commit
- busy_o  out  1  sequence in flight
- done_o  out  1  one-cycle pulse when a sequence ends
- timeout_o  out  1  one-cycle pulse when a sequence is aborted by timeout

Behaviour:
- Reset: state IDLE; all outputs 0; pending masks and counter cleared. Reset mid-sequence aborts immediately; no done_o is produced.
- States: IDLE, FLUSH_D, FLUSH_I, DONE.
- IDLE, any request high (accept cycle). Combinational, same-cycle outputs:
  - set_pc_commit_o = 1 and flush_pipeline_o = 1.
  - sfence.vma: flush_tlb_vvma_o if v_i, else flush_tlb_o.
  - hfence.vvma -> flush_tlb_vvma_o; hfence.gvma -> flush_tlb_gvma_o.
  - Simultaneous requests: the union of all actions is performed.
- Next state from IDLE on accept:
  - Latch need_i = fence_i_req_i.
  - If DcacheWb and (fence or fence.i): pending_d = all ones -> FLUSH_D.
  - Else if need_i and IcacheAck -> FLUSH_I.
  - Else if need_i: pulse flush_icache_o in the accept cycle -> DONE.
  - Else -> DONE.
- FLUSH_D:
  - flush_dcache_o = pending_d (registered; first high the cycle after accept).
  - Bit k clears on flush_dcache_ack_i[k] while pending_d[k]=1. Acks on non-pending channels are ignored.
  - When pending_d becomes 0: if need_i and IcacheAck -> FLUSH_I; if need_i and !IcacheAck -> pulse flush_icache_o for one cycle, then DONE; otherwise DONE.
  - Acks on all channels in the same cycle complete the phase in that cycle.
- FLUSH_I: flush_icache_o held high until flush_icache_ack_i, then DONE.
- DONE: done_o = 1 for one cycle -> IDLE.
- Timeout counter:
  - Cleared on entry to FLUSH_D/FLUSH_I; increments each cycle in those states.
  - When it reaches TimeoutCycles (and TimeoutCycles != 0): clear all pending requests, pulse timeout_o, go to DONE (done_o follows next cycle).
- halt_o = halt_csr_i | (state != IDLE). busy_o = (state != IDLE).
- Requests arriving while not IDLE are ignored (commit is halted); this is covered by an assertion.
- Ordering guarantee: I-cache flush never precedes completion of D-cache writeback.

Decomposition:
- Shared package: flush_state_e (IDLE, FLUSH_D, FLUSH_I, DONE) and fence_op_t struct (fence, fence_i, sfence, hvvma, hgvma).
- One sub-module, flush_ack_tracker:
  - Parametrised by channel count.
  - Load-all, per-bit clear on ack, all_done output.
  - Instanced once for the D-cache channels.

Test Plan:
- fence_req_i=1 in one cycle, DcacheWb=1, NrDcacheChan=2 -> set_pc_commit_o=1 that cycle; flush_dcache_o=2'b11 next cycle. Ack ch0 at +3 -> 2'b10. Ack ch1 at +5 -> 2'b00. done_o at +6. halt_o high from +1..+6.
- fence_i_req_i with IcacheAck=1 -> flush_icache_o stays 0 until both D acks; then held high until flush_icache_ack_i; done_o next cycle.
- sfence_vma_i with v_i=1 -> flush_tlb_vvma_o=1, flush_tlb_o=0, done_o next cycle. Same with v_i=0 -> flush_tlb_o=1.
- fence_req_i + hfence_gvma_i in the same cycle -> flush_tlb_gvma_o=1 that cycle and D-cache flush sequence runs.
- TimeoutCycles=16, ch1 never acks -> flush_dcache_o drops to 0 and timeout_o pulses 16 cycles after entering FLUSH_D; done_o follows; halt_o then 0.
- rst_i asserted mid FLUSH_D -> all outputs 0 asynchronously; after release, state IDLE and a new fence is accepted normally.
